// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scanner: glyph codes, segment patterns, code width.
package seg_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] CODE_BLANK = 5'h10;
  localparam logic [CODE_W-1:0] CODE_L     = 5'h11;
  localparam logic [CODE_W-1:0] CODE_H     = 5'h12;
  localparam logic [CODE_W-1:0] CODE_DASH  = 5'h13;

  // Active-low patterns, bit7=a .. bit1=g, bit0=h (decimal point).
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_A     = 8'b0001_0001;
  localparam logic [7:0] SEG_B     = 8'b1100_0001;
  localparam logic [7:0] SEG_C     = 8'b0110_0011;
  localparam logic [7:0] SEG_D     = 8'b1000_0101;
  localparam logic [7:0] SEG_E     = 8'b0110_0001;
  localparam logic [7:0] SEG_F     = 8'b0111_0001;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
  localparam logic [7:0] SEG_L     = 8'b1110_0011;
  localparam logic [7:0] SEG_H     = 8'b1001_0001;
  localparam logic [7:0] SEG_DASH  = 8'b1111_1101;

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph decoder: 5-bit code to active-low segment pattern (dp left dark).
module seg_decode
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [7:0]        pattern
);

  // Hex digits, octave letters and dash; every unused code is dark.
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      5'h00:     pattern = SEG_0;
      5'h01:     pattern = SEG_1;
      5'h02:     pattern = SEG_2;
      5'h03:     pattern = SEG_3;
      5'h04:     pattern = SEG_4;
      5'h05:     pattern = SEG_5;
      5'h06:     pattern = SEG_6;
      5'h07:     pattern = SEG_7;
      5'h08:     pattern = SEG_8;
      5'h09:     pattern = SEG_9;
      5'h0A:     pattern = SEG_A;
      5'h0B:     pattern = SEG_B;
      5'h0C:     pattern = SEG_C;
      5'h0D:     pattern = SEG_D;
      5'h0E:     pattern = SEG_E;
      5'h0F:     pattern = SEG_F;
      CODE_BLANK: pattern = SEG_BLANK;
      CODE_L:    pattern = SEG_L;
      CODE_H:    pattern = SEG_H;
      CODE_DASH: pattern = SEG_DASH;
      default:   pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner with tear-free shadow registers.
// Optional blink support is compiled in with the macro SEG_SCAN_BLINK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CODE_W*DIGITS-1:0] codes,
  input  logic [DIGITS-1:0]        dp_mask,
  input  logic [DIGITS-1:0]        blank_mask,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]        blink_mask,
`endif
  input  logic                     load,
  output logic [DIGITS-1:0]        sel,
  output logic [7:0]               data,
  output logic                     frame_done
);

  localparam int PRESC_W = $clog2(CLK_DIV);
  localparam int IDX_W   = $clog2(DIGITS);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0][CODE_W-1:0] CODES_RST = {DIGITS{CODE_BLANK}};

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pend_q, pend_d;

  logic [DIGITS-1:0][CODE_W-1:0] stg_codes_q, stg_codes_d;
  logic [DIGITS-1:0]             stg_dp_q, stg_dp_d;
  logic [DIGITS-1:0]             stg_blank_q, stg_blank_d;
  logic [DIGITS-1:0][CODE_W-1:0] dsp_codes_q, dsp_codes_d;
  logic [DIGITS-1:0]             dsp_dp_q, dsp_dp_d;
  logic [DIGITS-1:0]             dsp_blank_q, dsp_blank_d;

  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        data_q, data_d;
  logic              frame_done_q, frame_done_d;

  logic              tick, wrap;
  logic [7:0]        glyph;

`ifdef SEG_SCAN_BLINK_EN
  localparam int FCNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic [DIGITS-1:0] stg_blink_q, stg_blink_d;
  logic [DIGITS-1:0] dsp_blink_q, dsp_blink_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              blink_off_q, blink_off_d;
`endif

  seg_decode u_decode (
    .code    (dsp_codes_q[idx_q]),
    .pattern (glyph)
  );

  // Next-state: prescaler/scan index, staging/display shadowing, registered outputs.
  always_comb begin
    tick = (presc_q == PRESC_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    stg_codes_d = stg_codes_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    dsp_codes_d = dsp_codes_q;
    dsp_dp_d    = dsp_dp_q;
    dsp_blank_d = dsp_blank_q;
    pend_d      = pend_q;
`ifdef SEG_SCAN_BLINK_EN
    stg_blink_d = stg_blink_q;
    dsp_blink_d = dsp_blink_q;
    fcnt_d      = fcnt_q;
    blink_off_d = blink_off_q;
    if (wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d      = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
`endif

    // Display copies the old staging before a same-cycle load overwrites it,
    // so a load landing on the boundary is shown one frame later.
    if (wrap && pend_q) begin
      dsp_codes_d = stg_codes_q;
      dsp_dp_d    = stg_dp_q;
      dsp_blank_d = stg_blank_q;
`ifdef SEG_SCAN_BLINK_EN
      dsp_blink_d = stg_blink_q;
`endif
      pend_d      = 1'b0;
    end
    if (load) begin
      stg_codes_d = codes;
      stg_dp_d    = dp_mask;
      stg_blank_d = blank_mask;
`ifdef SEG_SCAN_BLINK_EN
      stg_blink_d = blink_mask;
`endif
      pend_d      = 1'b1;
    end

    sel_d  = ~(DIGITS'(1) << idx_q);
    data_d = glyph;
    if (dsp_dp_q[idx_q]) data_d[0] = 1'b0;
    if (dsp_blank_q[idx_q]) data_d = SEG_BLANK;
`ifdef SEG_SCAN_BLINK_EN
    if (blink_off_q && dsp_blink_q[idx_q]) data_d = SEG_BLANK;
`endif
    frame_done_d = wrap;
  end

  // State and output registers; reset returns to a dark, blank display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      stg_codes_q  <= CODES_RST;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      dsp_codes_q  <= CODES_RST;
      dsp_dp_q     <= '0;
      dsp_blank_q  <= '0;
      sel_q        <= '1;
      data_q       <= SEG_BLANK;
      frame_done_q <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
      stg_blink_q  <= '0;
      dsp_blink_q  <= '0;
      fcnt_q       <= '0;
      blink_off_q  <= 1'b0;
`endif
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      stg_codes_q  <= stg_codes_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      dsp_codes_q  <= dsp_codes_d;
      dsp_dp_q     <= dsp_dp_d;
      dsp_blank_q  <= dsp_blank_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
`ifdef SEG_SCAN_BLINK_EN
      stg_blink_q  <= stg_blink_d;
      dsp_blink_q  <= dsp_blink_d;
      fcnt_q       <= fcnt_d;
      blink_off_q  <= blink_off_d;
`endif
    end
  end

  assign sel        = sel_q;
  assign data       = data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=4, CLK_DIV=4 (16-clock frames).
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] codes;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        load;
  logic [3:0]  sel;
  logic [7:0]  data;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  seg_scan_mux #(.DIGITS(4), .CLK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .codes      (codes),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .load       (load),
    .sel        (sel),
    .data       (data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [19:0] c, input logic [3:0] dp, input logic [3:0] bl);
    codes      = c;
    dp_mask    = dp;
    blank_mask = bl;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // Advance to the next negedge where frame_done is high (bounded).
  task automatic wait_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $error("FAIL %s timeout waiting for frame_done observed=0 expected=1", tag);
    end
  endtask

  // Called on the frame_done cycle; checks each digit's first lit cycle, ends on digit 3.
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    step(1);
    chk({tag, "_sel0"}, {4'b0, sel}, 8'b0000_1110);
    chk({tag, "_d0"}, data, e0);
    step(4);
    chk({tag, "_sel1"}, {4'b0, sel}, 8'b0000_1101);
    chk({tag, "_d1"}, data, e1);
    step(4);
    chk({tag, "_sel2"}, {4'b0, sel}, 8'b0000_1011);
    chk({tag, "_d2"}, data, e2);
    step(4);
    chk({tag, "_sel3"}, {4'b0, sel}, 8'b0000_0111);
    chk({tag, "_d3"}, data, e3);
  endtask

  initial begin
    int gap;
    rst = 1'b1;
    codes = '0;
    dp_mask = '0;
    blank_mask = '0;
    load = 1'b0;
    step(3);
    chk("rst_sel", {4'b0, sel}, 8'b0000_1111);
    chk("rst_data", data, 8'hFF);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);

    // 1: free scan with blank display
    rst = 1'b0;
    step(1);
    chk("t1_sel0", {4'b0, sel}, 8'b0000_1110);
    chk("t1_d0", data, 8'hFF);
    step(3);
    chk("t1_sel0_last", {4'b0, sel}, 8'b0000_1110);
    step(1);
    chk("t1_sel1", {4'b0, sel}, 8'b0000_1101);
    chk("t1_d1", data, 8'hFF);
    step(4);
    chk("t1_sel2", {4'b0, sel}, 8'b0000_1011);
    step(4);
    chk("t1_sel3", {4'b0, sel}, 8'b0000_0111);
    chk("t1_d3", data, 8'hFF);
    step(2);
    chk("t1_fd_pre", {7'b0, frame_done}, 8'h00);
    step(1);
    chk("t1_fd", {7'b0, frame_done}, 8'h01);
    chk("t1_fd_sel", {4'b0, sel}, 8'b0000_0111);
    step(1);
    chk("t1_fd_post", {7'b0, frame_done}, 8'h00);
    chk("t1_wrap_sel", {4'b0, sel}, 8'b0000_1110);
    gap = 1;
    while (frame_done !== 1'b1 && gap < 40) begin
      step(1);
      gap++;
    end
    chk("t1_period", 8'(gap), 8'd16);

    // 2: load takes effect only at the next frame
    do_load({5'h12, 5'h07, 5'h03, 5'h01}, 4'b0000, 4'b0000);
    chk("t2_mid_d0", data, 8'hFF);
    wait_frame("t2_wait");
    check_frame("t2", 8'b1001_1111, 8'b0000_1101, 8'b0001_1111, 8'b1001_0001);

    // 3: two loads in one frame, last wins
    wait_frame("t3_wait");
    step(2);
    do_load({5'h0D, 5'h0C, 5'h0B, 5'h0A}, 4'b0000, 4'b0000);
    step(3);
    chk("t3_mid_d1", data, 8'b0000_1101);
    do_load({5'h13, 5'h0E, 5'h0F, 5'h11}, 4'b0000, 4'b0000);
    wait_frame("t3_wait2");
    check_frame("t3", 8'b1110_0011, 8'b0111_0001, 8'b0110_0001, 8'b1111_1101);

    // 4: load on the wrap cycle shows one frame late
    wait_frame("t4_wait");
    do_load({5'h02, 5'h09, 5'h06, 5'h05}, 4'b0000, 4'b0000);
    step(14);
    codes = {5'h0D, 5'h0C, 5'h04, 5'h00};
    load = 1'b1;
    step(1);
    load = 1'b0;
    chk("t4_load_on_wrap", {7'b0, frame_done}, 8'h01);
    check_frame("t4a", 8'b0100_1001, 8'b0100_0001, 8'b0000_1001, 8'b0010_0101);
    wait_frame("t4_wait2");
    check_frame("t4b", 8'b0000_0011, 8'b1001_1001, 8'b0110_0011, 8'b1000_0101);

    // 5: dp and blank masks
    do_load({5'h08, 5'h08, 5'h08, 5'h08}, 4'b0001, 4'b0010);
    wait_frame("t5_wait");
    check_frame("t5", 8'b0000_0000, 8'hFF, 8'b0000_0001, 8'b0000_0001);

    // blank overrides dp; unused codes are dark but still take dp
    do_load({5'h1F, 5'h14, 5'h0B, 5'h10}, 4'b1011, 4'b0001);
    wait_frame("t5b_wait");
    check_frame("t5b", 8'hFF, 8'b1100_0000, 8'hFF, 8'b1111_1110);

    // 6: reset mid-digit discards a pending load
    step(1);
    do_load({5'h08, 5'h08, 5'h08, 5'h08}, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    chk("t6_rst_sel", {4'b0, sel}, 8'b0000_1111);
    chk("t6_rst_data", data, 8'hFF);
    chk("t6_rst_fd", {7'b0, frame_done}, 8'h00);
    step(2);
    rst = 1'b0;
    step(1);
    chk("t6_restart_sel", {4'b0, sel}, 8'b0000_1110);
    chk("t6_restart_d0", data, 8'hFF);
    wait_frame("t6_wait");
    check_frame("t6", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised multiplexed 7-segment scanner for the piano front panel. Generalises the fixed two-digit display to DIGITS time-multiplexed digits.
- Has a free-running refresh prescaler, a per-digit glyph decode that includes the octave letters, and per-digit decimal point and blanking.
- Uses a tear-free shadow register: new codes take effect only at a frame boundary.
- Sits between the note/octave logic and the board's common-anode display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- CLK_DIV, 50000, clk cycles each digit is lit (>=2).
- BLINK_FRAMES, 64, frames per blink half-period (used only with the blink feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- codes  in  5*DIGITS  glyph code per digit; digit i is at [5i+4:5i]; digit 0 is the rightmost.
- dp_mask  in  DIGITS  1 = light the decimal point of digit i.
- blank_mask  in  DIGITS  1 = force digit i dark.
- load  in  1  one-cycle strobe; captures codes/dp_mask/blank_mask into staging.
- sel  out  DIGITS  active-low digit enable, one-hot-low.
- data  out  8  active-low segments, {a,b,c,d,e,f,g,h}; h is the dp.
- frame_done  out  1  one-cycle pulse when the scan wraps from DIGITS-1 to 0.

Behaviour:
- Reset is asynchronous, active-high; one clock domain (clk).
- Reset values:
  - prescaler=0, idx=0, pending=0.
  - staging/display codes=0x10 (blank); masks=0.
  - sel=all ones, data=8'hFF, frame_done=0.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick = (prescaler==CLK_DIV-1).
- On tick, idx increments. At DIGITS-1 it wraps to 0, and the wrap cycle is the frame boundary.
- sel and data are registered from the current idx:
  - sel <= ~(1<<idx).
  - data <= decode(display code[idx]), with dp and blank applied.
  - Latency: outputs follow an idx change by 1 cycle, so each digit is lit exactly CLK_DIV cycles.
- frame_done is registered. It is high for exactly the 1 cycle after the tick that wraps idx to 0.
- Shadow buffering:
  - load: staging <= inputs, pending <= 1.
  - At the frame boundary with pending=1: display <= staging, pending <= 0.
  - load in the same cycle as the boundary: display takes the old staging, staging takes the new inputs, pending stays 1, so the new values show next frame.
  - Multiple loads within one frame: the last one wins.
- Decode (5-bit code to active-low pattern, bit7=a .. bit0=h):
  - 0x00-0x0F: hex digits. 0=0000_0011, 1=1001_1111, 2=0010_0101, 3=0000_1101, 4=1001_1001, 5=0100_1001, 6=0100_0001, 7=0001_1111, 8=0000_0001, 9=0000_1001, A=0001_0001, b=1100_0001, C=0110_0011, d=1000_0101, E=0110_0001, F=0111_0001.
  - 0x10 blank=1111_1111.
  - 0x11 'L'=1110_0011; 0x12 'H'=1001_0001; 0x13 '-'=1111_1101.
  - 0x14-0x1F: blank.
- Priority: blank_mask -> data=8'hFF, overriding both dp and glyph. Otherwise dp_mask clears bit0.
- Reset mid-frame: immediate return to reset values, and any pending load is discarded.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- When defined:
  - Adds input blink_mask[DIGITS-1:0]; it is staged and shadowed exactly like blank_mask.
  - A frame counter toggles a blink phase every BLINK_FRAMES frame boundaries; phase resets to "on".
  - In the off phase, digits with blink set output 8'hFF.
- When undefined: no port, no counter, behaviour as above.

Decomposition:
- Package seg_pkg holds:
  - code constants CODE_BLANK, CODE_L, CODE_H, CODE_DASH;
  - the 8-bit SEG_* pattern constants;
  - the code width (5).
- Sub-module seg_decode: purely combinational, code[4:0] to pattern[7:0]. Instantiated once and fed the idx-selected code.

Test Plan (DIGITS=4, CLK_DIV=4):
1. Reset, then no load -> sel cycles 1110,1101,1011,0111, each for 4 clocks; data=8'hFF throughout; frame_done pulses once every 16 clocks.
2. load with codes {0x12,0x07,0x03,0x01} -> from the next frame, digits 0..3 show 1001_1111, 0000_1101, 0001_1111, 1001_0001; nothing changes mid-frame.
3. load mid-frame, then a second load with digit0=0x11 in the same frame -> the next frame shows only the second set (digit0 data=1110_0011).
4. load asserted exactly on the wrap tick -> the following frame shows the previous staging; the new values show one frame later.
5. dp_mask=0001, blank_mask=0010, codes all 0x08 -> digit0=0000_0000, digit1=1111_1111, digits2/3=0000_0001.
6. Assert rst mid-digit -> outputs are immediately sel=1111, data=FF; after release, the scan restarts at digit 0 with blank display.
